// File: rtl/proc_selftest_ctrl_if.sv
// Signal bundle between the self-test sequencer and the processor/host side.
// The sequencer drives processor reset, start PC and the result flags; the
// other side supplies the start request and the processor observations.
interface proc_selftest_ctrl_if;
    logic        start;
    logic [63:0] currentpc;
    logic [63:0] dmemout;
    logic        resetl;
    logic [63:0] startpc;
    logic        done;
    logic        pass;
    logic [7:0]  passcount;
    logic [1:0]  first_fail;
    logic        timeout;

    modport master (
        input  start, currentpc, dmemout,
        output resetl, startpc, done, pass, passcount, first_fail, timeout
    );

    modport slave (
        output start, currentpc, dmemout,
        input  resetl, startpc, done, pass, passcount, first_fail, timeout
    );
endinterface

// File: rtl/proc_selftest_ctrl.sv
// Self-test sequencer for the single-cycle processor: holds the core in
// reset, releases it, samples data-memory output at two PC checkpoints and
// flags a watchdog timeout if the program never reaches them.
module proc_selftest_ctrl #(
    parameter logic [63:0] START_PC     = 64'h0,
    parameter logic [15:0] RESET_CYCLES = 16'd1,
    parameter logic [63:0] CHECK_PC0    = 64'h34,
    parameter logic [63:0] CHECK_VAL0   = 64'hF,
    parameter logic [63:0] CHECK_PC1    = 64'h64,
    parameter logic [63:0] CHECK_VAL1   = 64'h123456789abcdef0,
    parameter logic [15:0] WDOG_LIMIT   = 16'hFF
) (
    input  logic                  CLK,
    input  logic                  reset,
    proc_selftest_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic        idx_r, idx_s;
    logic [15:0] rcnt_r, rcnt_s;
    logic [15:0] wdog_r, wdog_s;
    logic [7:0]  passcount_r, passcount_s;
    logic [1:0]  first_fail_r, first_fail_s;
    logic        timeout_r, timeout_s;
    logic        resetl_r, resetl_s;
    logic        done_r, done_s;

    logic [63:0] chk_pc_s;
    logic [63:0] chk_val_s;
    logic [15:0] wdog_inc_s;
    logic        wdog_hit_s;
    logic        pc_hit_s;
    logic        val_ok_s;

    // Checkpoint selection and the watchdog / PC / data comparisons.
    // The watchdog counts the current cycle too, so expiry lands exactly
    // WDOG_LIMIT run cycles after the processor leaves reset.
    always_comb begin
        chk_pc_s   = idx_r ? CHECK_PC1 : CHECK_PC0;
        chk_val_s  = idx_r ? CHECK_VAL1 : CHECK_VAL0;
        wdog_inc_s = wdog_r + 16'd1;
        wdog_hit_s = ((state_r == ST_RUN) || (state_r == ST_SETTLE)) && (wdog_inc_s == WDOG_LIMIT);
        pc_hit_s   = (bus.currentpc >= chk_pc_s);
        val_ok_s   = (bus.dmemout == chk_val_s);
    end

    // State register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; watchdog expiry overrides any checkpoint progress.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   if (bus.start) state_s = ST_RST; else state_s = ST_IDLE;
            ST_RST:    if (rcnt_r <= 16'd1) state_s = ST_RUN; else state_s = ST_RST;
            ST_RUN: begin
                if (wdog_hit_s)    state_s = ST_DONE;
                else if (pc_hit_s) state_s = ST_SETTLE;
                else               state_s = ST_RUN;
            end
            ST_SETTLE: begin
                if (wdog_hit_s) state_s = ST_DONE;
                else if (idx_r) state_s = ST_DONE;
                else            state_s = ST_RUN;
            end
            ST_DONE:   if (bus.start) state_s = ST_RST; else state_s = ST_DONE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Next values for counters, results and the registered outputs.
    always_comb begin
        idx_s        = idx_r;
        rcnt_s       = rcnt_r;
        wdog_s       = wdog_r;
        passcount_s  = passcount_r;
        first_fail_s = first_fail_r;
        timeout_s    = timeout_r;
        resetl_s     = (state_s == ST_RUN) || (state_s == ST_SETTLE) || (state_s == ST_DONE);
        done_s       = (state_s == ST_DONE);
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    passcount_s  = 8'd0;
                    first_fail_s = 2'd3;
                    timeout_s    = 1'b0;
                    wdog_s       = 16'd0;
                    rcnt_s       = RESET_CYCLES;
                end else begin
                    rcnt_s = rcnt_r;
                end
            end
            ST_RST: begin
                if (rcnt_r <= 16'd1) begin
                    idx_s  = 1'b0;
                    wdog_s = 16'd0;
                    rcnt_s = 16'd0;
                end else begin
                    rcnt_s = rcnt_r - 16'd1;
                end
            end
            ST_RUN: begin
                wdog_s = wdog_inc_s;
                if (wdog_hit_s) timeout_s = 1'b1; else timeout_s = timeout_r;
            end
            ST_SETTLE: begin
                wdog_s = wdog_inc_s;
                if (wdog_hit_s) begin
                    timeout_s = 1'b1;
                end else begin
                    if (val_ok_s) begin
                        passcount_s = passcount_r + 8'd1;
                    end else if (first_fail_r == 2'd3) begin
                        first_fail_s = {1'b0, idx_r};
                    end else begin
                        first_fail_s = first_fail_r;
                    end
                    if (!idx_r) idx_s = 1'b1; else idx_s = idx_r;
                end
            end
            default: begin
                idx_s = idx_r;
            end
        endcase
    end

    // Result, counter and output registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            idx_r        <= 1'b0;
            rcnt_r       <= 16'd0;
            wdog_r       <= 16'd0;
            passcount_r  <= 8'd0;
            first_fail_r <= 2'd3;
            timeout_r    <= 1'b0;
            resetl_r     <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            idx_r        <= idx_s;
            rcnt_r       <= rcnt_s;
            wdog_r       <= wdog_s;
            passcount_r  <= passcount_s;
            first_fail_r <= first_fail_s;
            timeout_r    <= timeout_s;
            resetl_r     <= resetl_s;
            done_r       <= done_s;
        end
    end

    assign bus.resetl     = resetl_r;
    assign bus.startpc    = START_PC;
    assign bus.done       = done_r;
    assign bus.passcount  = passcount_r;
    assign bus.first_fail = first_fail_r;
    assign bus.timeout    = timeout_r;
    assign bus.pass       = done_r & ~timeout_r & (passcount_r == 8'd2);

endmodule
